// File: rtl/compress_stream_pipe.sv
// compress_stream_pipe: streaming multi-lane FP32 sparsity compressor.
// Each lane is classified by exponent into ZERO / 8-bit / 16-bit / RAW.
// Each beat yields a 2-bit-per-lane bitmap, a densely packed LSB-aligned
// payload and its byte count.
// Two elastic stages: S1 holds classified/converted lanes, S2 holds the
// packed output registers.
module compress_stream_pipe #(
    parameter int LANES      = 4,
    parameter int E_ZERO     = 112,
    parameter int E_16       = 120,
    parameter int E_8        = 127,
    parameter int SWAP_BYTES = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [32*LANES-1:0]              in_data,
    input  logic                             cfg_bypass,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [2*LANES-1:0]               out_bitmap,
    output logic [32*LANES-1:0]              out_payload,
    output logic [$clog2(4*LANES+1)-1:0]     out_bytes
);

    localparam int PW = 32 * LANES;
    localparam int BW = $clog2(4 * LANES + 1);

    localparam logic [7:0] LP_EZ = 8'(E_ZERO);
    localparam logic [7:0] LP_E16 = 8'(E_16);
    localparam logic [7:0] LP_E8 = 8'(E_8);

    // Optional byte reversal so big-endian sources can be fed directly.
    function automatic logic [31:0] f_swap(input logic [31:0] w);
        if (SWAP_BYTES != 0)
            return {w[7:0], w[15:8], w[23:16], w[31:24]};
        else
            return w;
    endfunction

    // Lane class from the exponent; bypass forces RAW. Inf/NaN land in RAW.
    function automatic logic [1:0] f_class(input logic [7:0] e, input logic byp);
        if (byp || e >= LP_E8) return 2'b11;
        else if (e < LP_EZ)    return 2'b00;
        else if (e < LP_E16)   return 2'b10;
        else                   return 2'b01;
    endfunction

    // Reduced-precision value, LSB-aligned, upper bits zero for short classes.
    function automatic logic [31:0] f_conv(input logic [31:0] w, input logic [1:0] code);
        logic [7:0]  sh;
        logic [23:0] r;
        sh = 8'd127 - w[30:23];
        r  = {1'b1, w[22:0]} >> sh;
        case (code)
            2'b00:   return 32'd0;
            2'b01:   return {24'd0, w[31], 7'(r >> 16)};
            2'b10:   return {16'd0, w[31], 15'(r >> 8)};
            default: return w;
        endcase
    endfunction

    // Payload bytes contributed by one lane.
    function automatic logic [BW-1:0] f_size(input logic [1:0] code);
        case (code)
            2'b00:   return BW'(0);
            2'b01:   return BW'(1);
            2'b10:   return BW'(2);
            default: return BW'(4);
        endcase
    endfunction

    logic              r_vld_p1;
    logic [1:0]        r_code_p1 [LANES];
    logic [31:0]       r_val_p1  [LANES];

    logic [1:0]        w_code_in [LANES];
    logic [31:0]       w_val_in  [LANES];
    logic [31:0]       w_word    [LANES];

    logic              w_s2_rdy;
    logic              w_s1_adv;
    logic              w_in_fire;

    logic [2*LANES-1:0] w_bitmap;
    logic [PW-1:0]      w_payload;
    logic [BW-1:0]      w_bytes;

    // S2 can take a beat when empty or draining; S1 likewise via S2.
    assign w_s2_rdy  = !out_valid || out_ready;
    assign w_s1_adv  = r_vld_p1 && w_s2_rdy;
    assign in_ready  = !r_vld_p1 || w_s2_rdy;
    assign w_in_fire = in_valid && in_ready;

    // ---- input -> S1: classify and convert each lane of the incoming beat
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_word[i]    = f_swap(in_data[32*i +: 32]);
            w_code_in[i] = f_class(w_word[i][30:23], cfg_bypass);
            w_val_in[i]  = f_conv(w_word[i], w_code_in[i]);
        end
    end

    // S1 occupancy; reset drops any in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_vld_p1 <= 1'b0;
        else if (in_ready)
            r_vld_p1 <= in_valid;
    end

    // S1 lane data, captured together with cfg_bypass only on an accepted beat.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            for (int i = 0; i < LANES; i++) begin
                r_code_p1[i] <= w_code_in[i];
                r_val_p1[i]  <= w_val_in[i];
            end
        end
    end

    // ---- S1 -> S2: pack lanes back to back starting at bit 0
    always_comb begin
        w_bitmap  = '0;
        w_payload = '0;
        w_bytes   = '0;
        for (int i = 0; i < LANES; i++) begin
            w_bitmap[2*i +: 2] = r_code_p1[i];
            w_payload = w_payload | (PW'(r_val_p1[i]) << (8 * int'(w_bytes)));
            w_bytes   = w_bytes + f_size(r_code_p1[i]);
        end
    end

    // S2 output registers; held while stalled, untouched when no beat arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_bitmap  <= '0;
            out_payload <= '0;
            out_bytes   <= '0;
        end else begin
            if (w_s2_rdy)
                out_valid <= r_vld_p1;
            if (w_s1_adv) begin
                out_bitmap  <= w_bitmap;
                out_payload <= w_payload;
                out_bytes   <= w_bytes;
            end
        end
    end

endmodule

// File: tb/tb_compress_stream_pipe.sv
// Directed bench for compress_stream_pipe: fixed vectors with hand-computed
// bitmap/payload/byte-count values, streaming with backpressure, bypass,
// byte-swap and mid-flight reset.
module tb_compress_stream_pipe;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, cfg_bypass;
    logic [127:0]  in_data;
    logic          out_valid, out_ready;
    logic [7:0]    out_bitmap;
    logic [127:0]  out_payload;
    logic [4:0]    out_bytes;

    logic          sw_in_valid, sw_in_ready, sw_cfg_bypass;
    logic [127:0]  sw_in_data;
    logic          sw_out_valid, sw_out_ready;
    logic [7:0]    sw_out_bitmap;
    logic [127:0]  sw_out_payload;
    logic [4:0]    sw_out_bytes;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] pat_d  [5];
    logic         pat_b  [5];
    logic [7:0]   pat_bm [5];
    logic [127:0] pat_pl [5];
    logic [4:0]   pat_by [5];
    int           seq    [8];
    logic         saw_stall;

    always #5 clk = ~clk;

    compress_stream_pipe #(.LANES(4), .SWAP_BYTES(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cfg_bypass(cfg_bypass),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bitmap(out_bitmap), .out_payload(out_payload), .out_bytes(out_bytes)
    );

    compress_stream_pipe #(.LANES(4), .SWAP_BYTES(1)) u_dut_sw (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sw_in_valid), .in_ready(sw_in_ready), .in_data(sw_in_data),
        .cfg_bypass(sw_cfg_bypass),
        .out_valid(sw_out_valid), .out_ready(sw_out_ready),
        .out_bitmap(sw_out_bitmap), .out_payload(sw_out_payload), .out_bytes(sw_out_bytes)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated beat with out_ready=1: exact 2-cycle latency, then idle.
    task automatic run_beat(input string tag, input int p);
        @(negedge clk);
        in_valid   = 1'b1;
        in_data    = pat_d[p];
        cfg_bypass = pat_b[p];
        check_eq({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_data    = 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0;
        cfg_bypass = ~pat_b[p];
        @(negedge clk);
        check_eq({tag, "_vld_early"}, 128'(out_valid), 128'(0));
        @(negedge clk);
        check_eq({tag, "_vld"}, 128'(out_valid), 128'(1));
        check_eq({tag, "_bitmap"}, 128'(out_bitmap), 128'(pat_bm[p]));
        check_eq({tag, "_payload"}, out_payload, pat_pl[p]);
        check_eq({tag, "_bytes"}, 128'(out_bytes), 128'(pat_by[p]));
        @(negedge clk);
        check_eq({tag, "_vld_after"}, 128'(out_valid), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // P0: zero / 0.5 / 2^-8 / 1.0
        pat_d[0]  = 128'h3F800000_3B800000_3F000000_00000000;
        pat_b[0]  = 1'b0;
        pat_bm[0] = 8'hE4;
        pat_pl[0] = 128'h003F800000008040;
        pat_by[0] = 5'd7;
        // P1: same data, bypass
        pat_d[1]  = pat_d[0];
        pat_b[1]  = 1'b1;
        pat_bm[1] = 8'hFF;
        pat_pl[1] = 128'h3F8000003B8000003F00000000000000;
        pat_by[1] = 5'd16;
        // P2: exponents 111 / 112 / 119 / 120
        pat_d[2]  = 128'h3C000000_3B800000_38000000_37800000;
        pat_b[2]  = 1'b0;
        pat_bm[2] = 8'h68;
        pat_pl[2] = 128'h0100800001;
        pat_by[2] = 5'd5;
        // P3: exponents 126 / 127 / 255, then -0.5
        pat_d[3]  = 128'hBF000000_7F800000_3F800000_3F000000;
        pat_b[3]  = 1'b0;
        pat_bm[3] = 8'h7D;
        pat_pl[3] = 128'hC07F8000003F80000040;
        pat_by[3] = 5'd10;
        // P4: P3 data, bypass
        pat_d[4]  = pat_d[3];
        pat_b[4]  = 1'b1;
        pat_bm[4] = 8'hFF;
        pat_pl[4] = 128'hBF0000007F8000003F8000003F000000;
        pat_by[4] = 5'd16;

        seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3;
        seq[4] = 4; seq[5] = 0; seq[6] = 2; seq[7] = 1;

        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        cfg_bypass    = 1'b0;
        out_ready     = 1'b0;
        sw_in_valid   = 1'b0;
        sw_in_data    = '0;
        sw_cfg_bypass = 1'b0;
        sw_out_ready  = 1'b1;
        saw_stall     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_bitmap", 128'(out_bitmap), 128'(0));
        check_eq("rst_payload", out_payload, 128'(0));
        check_eq("rst_bytes", 128'(out_bytes), 128'(0));
        check_eq("rst_sw_out_valid", 128'(sw_out_valid), 128'(0));
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", 128'(in_ready), 128'(1));

        // Basic classification, boundaries, bypass
        run_beat("t1", 0);
        run_beat("bnd_a", 2);
        run_beat("bnd_b", 3);
        run_beat("byp_t1", 1);
        run_beat("byp_b", 4);

        // Byte-swapped input
        @(negedge clk);
        sw_in_valid = 1'b1;
        sw_in_data  = 128'h0000003F;
        check_eq("sw_in_ready", 128'(sw_in_ready), 128'(1));
        @(posedge clk);
        #1;
        sw_in_valid = 1'b0;
        @(negedge clk);
        check_eq("sw_vld_early", 128'(sw_out_valid), 128'(0));
        @(negedge clk);
        check_eq("sw_vld", 128'(sw_out_valid), 128'(1));
        check_eq("sw_bitmap", 128'(sw_out_bitmap), 128'(8'h01));
        check_eq("sw_payload", sw_out_payload, 128'h40);
        check_eq("sw_bytes", 128'(sw_out_bytes), 128'(1));

        // Streaming with backpressure and per-beat bypass changes
        @(posedge clk);
        #1;
        fork
            begin
                int  p;
                int  cnt;
                logic acc;
                for (int k = 0; k < 8; k++) begin
                    p          = seq[k];
                    in_valid   = 1'b1;
                    in_data    = pat_d[p];
                    cfg_bypass = pat_b[p];
                    cnt        = 0;
                    acc        = 1'b0;
                    while (!acc && cnt < 50) begin
                        @(negedge clk);
                        acc = in_ready;
                        if (!acc) saw_stall = 1'b1;
                        @(posedge clk);
                        #1;
                        cnt++;
                    end
                    check_eq("stream_accept", 128'(acc), 128'(1));
                    cfg_bypass = ~pat_b[p];
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = !(c >= 3 && c <= 7);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
            begin
                int got;
                int guard;
                int q;
                got   = 0;
                guard = 0;
                while (got < 8 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                    if (out_valid) begin
                        q = seq[got];
                        check_eq("stream_bitmap", 128'(out_bitmap), 128'(pat_bm[q]));
                        check_eq("stream_payload", out_payload, pat_pl[q]);
                        check_eq("stream_bytes", 128'(out_bytes), 128'(pat_by[q]));
                        if (out_ready) got++;
                    end
                end
                check_eq("stream_count", 128'(got), 128'(8));
            end
        join
        @(negedge clk);
        check_eq("stream_no_dup", 128'(out_valid), 128'(0));
        check_eq("stream_in_ready_dropped", 128'(saw_stall), 128'(1));

        // Reset with both stages full and output stalled
        @(negedge clk);
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_data    = pat_d[2];
        cfg_bypass = 1'b0;
        @(posedge clk);
        #1;
        in_data = pat_d[3];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("full_out_valid", 128'(out_valid), 128'(1));
        check_eq("full_in_ready", 128'(in_ready), 128'(0));
        check_eq("full_bitmap", 128'(out_bitmap), 128'(pat_bm[2]));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("async_rst_bitmap", 128'(out_bitmap), 128'(0));
        check_eq("async_rst_payload", out_payload, 128'(0));
        check_eq("async_rst_bytes", 128'(out_bytes), 128'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        run_beat("post_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
